// File: rtl/ALU_exception.sv
// Shared ALU exception encodings, trap-enable bit positions and the exported
// trap state used by the host register map.
package ALU_exception;

  typedef enum logic [1:0] {
    NO_EXCEPTION       = 2'd0,
    DIVISION_BY_ZERO   = 2'd1,
    INVALID_SHIFT_IMM  = 2'd2,
    INVALID_ENDIAN_IMM = 2'd3
  } alu_exc_e;

  localparam int TRAP_EN_DIV0   = 0;
  localparam int TRAP_EN_SHIFT  = 1;
  localparam int TRAP_EN_ENDIAN = 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_TRAP    = 2'd1,
    ST_RELEASE = 2'd2
  } trap_state_e;

endpackage

// File: rtl/alu_exc_monitor_if.sv
// Retire-stage bus into the exception monitor, plus the monitor's state readback.
// Handshake: retire_valid qualifies every other retire field in the same cycle;
// there is no ready, because the monitor halts the core instead of back-pressuring.
interface alu_exc_monitor_if #(parameter int PC_W = 32);
  import ALU_exception::*;

  logic            retire_valid;
  logic [PC_W-1:0] retire_pc;
  logic [3:0]      retire_alu_ctrl;
  logic            retire_is32;
  alu_exc_e        arith_exc;
  trap_state_e     state_dbg;

  modport master (
    output retire_valid, retire_pc, retire_alu_ctrl, retire_is32, arith_exc,
    input  state_dbg
  );

  modport slave (
    input  retire_valid, retire_pc, retire_alu_ctrl, retire_is32, arith_exc,
    output state_dbg
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a clear in the same cycle as an
// increment wins.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/alu_exc_monitor.sv
// Retire-side ALU exception monitor: counts exceptions, captures the first
// enabled one, halts the core until the host acknowledges, then restarts.
module alu_exc_monitor
  import ALU_exception::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_exc_monitor_if.slave  rb,
  input  logic [2:0]        trap_en,
  input  logic              host_ack,
  input  logic              host_clear_cnt,
  output logic              core_halt,
  output logic              trap_valid,
  output logic [1:0]        trap_code,
  output logic [PC_W-1:0]   trap_pc,
  output logic [4:0]        trap_ctrl,
  output logic              irq,
  output logic [CNT_W-1:0]  cnt_div0,
  output logic [CNT_W-1:0]  cnt_shift,
  output logic [CNT_W-1:0]  cnt_endian,
  output logic              protocol_err
);

  trap_state_e     state_q, state_d;
  logic            halt_q, halt_d;
  logic            valid_q, valid_d;
  logic [1:0]      code_q, code_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [4:0]      ctrl_q, ctrl_d;
  logic            irq_q, irq_d;
  logic            perr_q, perr_d;

  // arith_exc may hold stale values between instructions; only a retire in
  // RUN is allowed to look at it.
  logic retire_ok;
  logic inc_div0, inc_shift, inc_endian, trap_hit;

  assign retire_ok  = rb.retire_valid && (state_q == ST_RUN);
  assign inc_div0   = retire_ok && (rb.arith_exc == DIVISION_BY_ZERO);
  assign inc_shift  = retire_ok && (rb.arith_exc == INVALID_SHIFT_IMM);
  assign inc_endian = retire_ok && (rb.arith_exc == INVALID_ENDIAN_IMM);
  assign trap_hit   = (inc_div0   && trap_en[TRAP_EN_DIV0])
                   || (inc_shift  && trap_en[TRAP_EN_SHIFT])
                   || (inc_endian && trap_en[TRAP_EN_ENDIAN]);

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    valid_d = valid_q;
    code_d  = code_q;
    pc_d    = pc_q;
    ctrl_d  = ctrl_q;
    irq_d   = 1'b0;
    perr_d  = perr_q;
    case (state_q)
      ST_RUN: begin
        if (trap_hit) begin
          state_d = ST_TRAP;
          halt_d  = 1'b1;
          valid_d = 1'b1;
          irq_d   = 1'b1;
          code_d  = rb.arith_exc;
          pc_d    = rb.retire_pc;
          ctrl_d  = {rb.retire_is32, rb.retire_alu_ctrl};
        end
      end
      ST_TRAP: begin
        if (rb.retire_valid) perr_d = 1'b1;
        if (host_ack) begin
          state_d = ST_RELEASE;
          valid_d = 1'b0;
        end
      end
      ST_RELEASE: begin
        // One-cycle restart guard: the core stays halted one more cycle.
        if (rb.retire_valid) perr_d = 1'b1;
        state_d = ST_RUN;
        halt_d  = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
        halt_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      halt_q  <= 1'b0;
      valid_q <= 1'b0;
      code_q  <= 2'd0;
      pc_q    <= '0;
      ctrl_q  <= 5'd0;
      irq_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      ctrl_q  <= ctrl_d;
      irq_q   <= irq_d;
      perr_q  <= perr_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_div0 (
    .clk(clk), .rst(rst), .inc(inc_div0), .clr(host_clear_cnt), .count(cnt_div0)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_shift (
    .clk(clk), .rst(rst), .inc(inc_shift), .clr(host_clear_cnt), .count(cnt_shift)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_endian (
    .clk(clk), .rst(rst), .inc(inc_endian), .clr(host_clear_cnt), .count(cnt_endian)
  );

  assign rb.state_dbg   = state_q;
  assign core_halt      = halt_q;
  assign trap_valid     = valid_q;
  assign trap_code      = code_q;
  assign trap_pc        = pc_q;
  assign trap_ctrl      = ctrl_q;
  assign irq            = irq_q;
  assign protocol_err   = perr_q;

endmodule

// File: doc/alu_exc_monitor.md
# alu_exc_monitor

Retire-side consumer of the ALU's 2-bit arithmetic exception code. It samples the exception code only on retiring ALU instructions and captures the first trapping exception with its PC and ALU control. It then halts the core and holds the trap record until the host acknowledges it, and keeps saturating per-type exception counters. It sits between the ALU/retire stage of the eBPF CPU and the host control/status register space.

## Interface
Parameters:
- PC_W, 32, width of the instruction PC.
- CNT_W, 16, width of each exception counter.

Ports:
- clk  input  1  core clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- retire_valid  input  1  an ALU instruction retires this cycle.
- retire_pc  input  PC_W  PC of the retiring instruction.
- retire_alu_ctrl  input  4  ALU control of the retiring instruction.
- retire_is32  input  1  32-bit op flag of the retiring instruction.
- arith_exc  input  2  ALU exception code; meaningful only when retire_valid=1.
- trap_en  input  3  per-code trap enable: bit0 DIVISION_BY_ZERO, bit1 INVALID_SHIFT_IMM, bit2 INVALID_ENDIAN_IMM.
- host_ack  input  1  single-cycle pulse that releases a trap.
- host_clear_cnt  input  1  single-cycle pulse that zeroes all counters.
- core_halt  output  1  stalls fetch/retire.
- trap_valid  output  1  trap record is valid.
- trap_code  output  2  captured exception code.
- trap_pc  output  PC_W  captured PC.
- trap_ctrl  output  5  {is32, ALU control} of the trapping instruction.
- irq  output  1  one-cycle pulse on trap entry.
- cnt_div0, cnt_shift, cnt_endian  output  CNT_W each  saturating counts.
- protocol_err  output  1  sticky flag: retire seen while halted.

## Operation
- Encodings come from the ALU_exception package: NO_EXCEPTION=2'd0, DIVISION_BY_ZERO=2'd1, INVALID_SHIFT_IMM=2'd2, INVALID_ENDIAN_IMM=2'd3.
- arith_exc is ignored unless retire_valid=1. The ALU output can hold stale values between instructions, so this qualification is mandatory.
- The FSM has three states: RUN, TRAP, RELEASE.
- RUN: on retire_valid with a nonzero code, the matching counter increments.
  - If the matching trap_en bit is 1, the block captures code, pc and {is32, ctrl} and moves to TRAP.
  - If the bit is 0, the block counts only and stays in RUN.
- TRAP: core_halt=1 and trap_valid=1, and the record is frozen.
  - host_ack moves the FSM to RELEASE.
  - retire_valid=1 sets protocol_err. That retire is neither counted nor captured.
- RELEASE: held for exactly one cycle with core_halt=1 and trap_valid=0, then returns to RUN. This is a restart guard.
  - retire_valid here also sets protocol_err.
- host_ack outside TRAP is ignored.
- Counters saturate at all-ones and do not wrap.
- If host_clear_cnt coincides with an increment, the clear wins and the result is 0.
- protocol_err is cleared only by rst.
- trap_en changes take effect on the next qualified retire. A mask change made while in TRAP does not cancel the current trap.

## Timing
- Reset values:
  - State RUN.
  - core_halt=0, trap_valid=0, irq=0, protocol_err=0.
  - trap_code=0, trap_pc=0, trap_ctrl=0.
  - All counters 0.
- All outputs are registered.
- A trapping retire at edge N produces, after edge N: core_halt=1, trap_valid=1, record valid, and irq=1 for that single cycle.
- A counter increment is visible after the same edge.
- host_ack sampled at edge M: after M the state is RELEASE, trap_valid=0 and core_halt=1. After M+1 the state is RUN and core_halt=0.
- The earliest the next retire can be accepted is at edge M+2.
- rst asserted mid-TRAP forces every output to its reset value immediately. No record survives reset.

## Structure
- The exception code typedef/enum and the trap_en bit positions belong in the shared ALU_exception package. The block imports that package and defines no local encodings.
- A trap state enum, if exported for the host register map, also goes in that package.
- One sub-module, sat_counter (parameter CNT_W; ports inc, clr, count), instantiated three times.

## Test plan
- Reset then a retire with arith_exc=1, trap_en=3'b111, pc=0x40, ctrl=4'h3:
  - After one edge: trap_valid=1, trap_code=1, trap_pc=0x40, trap_ctrl=5'h03, irq high for 1 cycle, cnt_div0=1.
- arith_exc=2 with retire_valid=0 for 10 cycles:
  - No counter changes, no trap, core_halt=0.
- trap_en=3'b000, five retires with code 3:
  - cnt_endian=5, trap_valid stays 0, core_halt stays 0.
- In TRAP, pulse host_ack at edge M:
  - trap_valid=0 after M, core_halt=0 after M+1.
  - A retire at M+1 sets protocol_err=1 and leaves the counters unchanged.
- CNT_W=4: seventeen code-2 retires with traps masked:
  - cnt_shift=15.
  - host_clear_cnt coincident with a further code-2 retire gives cnt_shift=0.
- Assert rst mid-TRAP:
  - All outputs return to reset values asynchronously.
  - After rst deasserts, a new code-1 retire traps normally.
